// File: rtl/memory_line_pipe.sv
// memory_line_pipe: line-granular backing memory with a fixed, configurable
// access latency. One full-line read or write is in flight at a time. Operands
// are captured when the request is accepted, and a one-cycle done pulse marks completion.
// Optional feature macro: MEMORY_LINE_WMASK_EN adds a per-word write mask.
// The debug input is reserved for simulation dump tooling and is ignored here.
// INIT_FILE is accepted for interface compatibility; this RTL does not preload
// the array.

package memory_line_pipe_pkg;
   typedef enum logic [1:0] {
      ACCESS_NONE  = 2'd0,
      ACCESS_READ  = 2'd1,
      ACCESS_WRITE = 2'd2
   } t_access_type;
endpackage

module memory_line_pipe
   import memory_line_pipe_pkg::*;
#(
   parameter int    WORD_BITS  = 32,
   parameter int    LINE_WORDS = 4,
   parameter int    DEPTH      = 512,
   parameter int    LATENCY    = 128,
   parameter int    ADDR_BITS  = 32,
   parameter string INIT_FILE  = ""
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [ADDR_BITS-1:0]            address,
   input  logic [WORD_BITS*LINE_WORDS-1:0] input_line,
   input  t_access_type                    access,
`ifdef MEMORY_LINE_WMASK_EN
   input  logic [LINE_WORDS-1:0]           write_mask,
`endif
   output logic [WORD_BITS*LINE_WORDS-1:0] output_line,
   output logic                            busy,
   output logic                            done,
   output logic                            error,
   output logic                            overrun,
   input  logic [7:0]                      debug
);

   localparam int LINE_BITS = WORD_BITS * LINE_WORDS;
   localparam int OFF       = $clog2(LINE_BITS / 8);
   localparam int IDX       = $clog2(DEPTH);
   localparam int CNT_BITS  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_BITS-1:0] LAT_M1 = CNT_BITS'(LATENCY - 1);
   localparam bit HAS_INIT  = (INIT_FILE != "");

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } t_state;

   t_state               state;
   t_state               state_next;
   logic                 accept;
   logic                 complete;
   logic                 req;
   logic [CNT_BITS-1:0]  count;
   logic [IDX-1:0]       lat_idx;
   logic                 lat_write;
   logic                 lat_oor;
   logic [LINE_BITS-1:0] lat_line;
   logic [LINE_BITS-1:0] stored_line;
   logic [LINE_BITS-1:0] merged_line;
`ifdef MEMORY_LINE_WMASK_EN
   logic [LINE_WORDS-1:0] lat_mask;
`endif

   logic [LINE_BITS-1:0] mem [DEPTH];

   // Byte-offset bits, debug selector and the image name have no hardware effect.
   logic unused_bits;
   assign unused_bits = ^{debug, address[OFF-1:0], HAS_INIT};

   assign req = (access != ACCESS_NONE);

   // State register; reset aborts any request in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Next state: accept only when idle, complete when the countdown hits zero.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      complete   = 1'b0;
      case (state)
         S_IDLE: begin
            if (req) begin
               accept     = 1'b1;
               state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (count == '0) begin
               complete   = 1'b1;
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Line currently stored at the latched index, and the line a write would store.
   always_comb begin
      stored_line = mem[lat_idx];
      merged_line = lat_line;
`ifdef MEMORY_LINE_WMASK_EN
      for (int w = 0; w < LINE_WORDS; w++) begin
         if (!lat_mask[w])
            merged_line[w*WORD_BITS +: WORD_BITS] = stored_line[w*WORD_BITS +: WORD_BITS];
      end
`endif
   end

   // Array write on the completion edge of an in-range write; contents survive reset.
   always_ff @(posedge clock) begin
      if (complete && lat_write && !lat_oor)
         mem[lat_idx] <= merged_line;
   end

   // Request latching, latency countdown and one-cycle status pulses.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         overrun     <= 1'b0;
         output_line <= '0;
         lat_idx     <= '0;
         lat_write   <= 1'b0;
         lat_oor     <= 1'b0;
         lat_line    <= '0;
`ifdef MEMORY_LINE_WMASK_EN
         lat_mask    <= '0;
`endif
      end else begin
         done    <= complete;
         error   <= complete && lat_oor;
         overrun <= (state == S_WAIT) && req;
         if (accept) begin
            count     <= LAT_M1;
            busy      <= 1'b1;
            lat_idx   <= address[OFF +: IDX];
            lat_oor   <= |(address >> (OFF + IDX));
            lat_write <= (access == ACCESS_WRITE);
            lat_line  <= input_line;
`ifdef MEMORY_LINE_WMASK_EN
            lat_mask  <= write_mask;
`endif
         end else if (state == S_WAIT && count != '0) begin
            count <= count - 1'b1;
         end
         if (complete) begin
            busy <= 1'b0;
            if (!lat_oor)
               output_line <= lat_write ? merged_line : stored_line;
         end
      end
   end

endmodule
